// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake and holds the IF/ID register.
// A one-entry skid buffer absorbs a response that lands during a stall.
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_f,
    input  logic                  flush_d,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_valid,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pcplus4_d,
    output logic                  valid_d
);

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] WORD_BYTES = DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        StFetch,
        StBuffered,
        StDrain
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc_f;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] pend_target;
    logic [DATA_WIDTH-1:0] skid_instr;
    logic [DATA_WIDTH-1:0] skid_pc;

    assign pc_plus4  = pc_f + WORD_BYTES;
    assign target    = PCTargetE & ALIGN_MASK;
    assign imem_addr = pc_f & ALIGN_MASK;
    assign imem_req  = rst_n && (state != StBuffered);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= StFetch;
            pc_f        <= RESET_PC;
            pend_target <= '0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            instr_d     <= NOP_INSTR;
            pc_d        <= '0;
            pcplus4_d   <= '0;
            valid_d     <= 1'b0;
        end else if (PCSrcE) begin
            valid_d <= 1'b0;
            instr_d <= NOP_INSTR;
            // A response still in flight must be swallowed before the new target is fetched.
            if (state != StBuffered && !imem_valid) begin
                pend_target <= target;
                state       <= StDrain;
            end else begin
                pc_f  <= target;
                state <= StFetch;
            end
        end else begin
            unique case (state)
                StFetch: begin
                    if (imem_valid) begin
                        pc_f <= pc_plus4;
                        if (stall_f) begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= pc_f;
                            state      <= StBuffered;
                        end else begin
                            instr_d   <= imem_rdata;
                            pc_d      <= pc_f;
                            pcplus4_d <= pc_plus4;
                            valid_d   <= 1'b1;
                        end
                    end
                end
                StBuffered: begin
                    if (!stall_f) begin
                        instr_d   <= skid_instr;
                        pc_d      <= skid_pc;
                        pcplus4_d <= skid_pc + WORD_BYTES;
                        valid_d   <= 1'b1;
                        state     <= StFetch;
                    end
                end
                StDrain: begin
                    if (imem_valid) begin
                        pc_f  <= pend_target;
                        state <= StFetch;
                    end
                end
                default: state <= StFetch;
            endcase
            // Flush overrides any word accepted into IF/ID on the same edge.
            if (flush_d) begin
                valid_d <= 1'b0;
                instr_d <= NOP_INSTR;
            end
        end
    end

endmodule
